muldiv_sched: RTL and testbench

- Sequencer placed between the main control unit and the shared multiply/divide datapath (Booth multiplier, restoring divider).
- Accepts one mult or div request and latches the operands.
- Holds the selected unit's control line high until that unit reports done, then commits the result to architectural HI/LO and releases the CPU stall.
- Also handles divide-by-zero, flush-abort and watchdog timeout.

---
 rtl/muldiv_sched.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// Sequencer between the control unit and the shared Booth multiplier / restoring divider.
// Latches one request, runs the selected unit, commits HI/LO, and handles div-by-zero, flush and watchdog.
module muldiv_sched #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 48
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             mult_ctrl,
  output logic             div_ctrl,
  output logic [WIDTH-1:0] unit_op_a,
  output logic [WIDTH-1:0] unit_op_b,
  output logic             unit_rst,
  input  logic             mult_done,
  input  logic             div_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    MRUN,
    DRUN,
    COMMIT,
    ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] resHi_q, resHi_d;
  logic [WIDTH-1:0] resLo_q, resLo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             wdAbort_q, wdAbort_d;

  always_comb begin
    state_d   = state_q;
    wd_d      = '0;
    opA_d     = opA_q;
    opB_d     = opB_q;
    resHi_d   = resHi_q;
    resLo_d   = resLo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    wdAbort_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Multiply takes priority; a simultaneous divide request is dropped.
        if (start_mult) begin
          opA_d   = op_a;
          opB_d   = op_b;
          state_d = MRUN;
        end else if (start_div) begin
          if (op_b == '0) begin
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            opA_d   = op_a;
            opB_d   = op_b;
            state_d = DRUN;
          end
        end
      end
      MRUN, DRUN: begin
        wd_d = wd_q + 1'b1;
        if (flush) begin
          state_d = ABORT;
        end else if (state_q == MRUN && mult_done) begin
          resHi_d = mult_hi;
          resLo_d = mult_lo;
          state_d = COMMIT;
        end else if (state_q == DRUN && div_done) begin
          resHi_d = div_hi;
          resLo_d = div_lo;
          state_d = COMMIT;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          wdAbort_d = 1'b1;
          state_d   = ABORT;
        end
      end
      COMMIT: begin
        // A late flush still cancels the architectural write.
        if (flush) begin
          state_d = ABORT;
        end else begin
          hi_d    = resHi_q;
          lo_d    = resLo_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      resHi_q   <= '0;
      resLo_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      wdAbort_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      resHi_q   <= resHi_d;
      resLo_q   <= resLo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      wdAbort_q <= wdAbort_d;
    end
  end

  // Unit controls decode straight from state so they fall with an asynchronous reset.
  assign mult_ctrl = (state_q == MRUN);
  assign div_ctrl  = (state_q == DRUN);
  assign unit_rst  = (state_q == ABORT);
  assign timeout   = (state_q == ABORT) && wdAbort_q;
  assign busy      = (state_q == MRUN) || (state_q == DRUN) || (state_q == ABORT);
  assign unit_op_a = opA_q;
  assign unit_op_b = opB_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign done      = done_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: behavioural 34-cycle mult/div units, a table of operations checked
// through a scoreboard queue, and hand-written flush, commit-flush, watchdog and reset sequences.
module tb_muldiv_sched;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 48;
  localparam int LAT     = 34;

  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_BOTH = 2'd2;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [7:0]  lat;
    logic [7:0]  mc;
    logic [7:0]  dc;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start_mult = 1'b0;
  logic             start_div = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             mult_ctrl, div_ctrl, unit_rst;
  logic [WIDTH-1:0] unit_op_a, unit_op_b;
  logic             mult_done, div_done;
  logic [WIDTH-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [WIDTH-1:0] hi_out, lo_out;
  logic             busy, done, div_zero, timeout;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  logic [63:0] archHiLo = '0;
  logic neverDone = 1'b0;
  int unsigned mCnt = 0;
  int unsigned dCnt = 0;
  vec_t vecs[8];

  muldiv_sched #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .start_mult(start_mult), .start_div(start_div), .flush(flush),
    .op_a(op_a), .op_b(op_b),
    .mult_ctrl(mult_ctrl), .div_ctrl(div_ctrl),
    .unit_op_a(unit_op_a), .unit_op_b(unit_op_b), .unit_rst(unit_rst),
    .mult_done(mult_done), .div_done(div_done),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Unit models: each raises its done level once its control has been high for LAT cycles.
  always @(posedge clock) begin
    if (unit_rst || !mult_ctrl) mCnt <= 0;
    else if (mCnt != LAT - 1) mCnt <= mCnt + 1;
    if (unit_rst || !div_ctrl) dCnt <= 0;
    else if (dCnt != LAT - 1) dCnt <= dCnt + 1;
  end

  assign mult_done = mult_ctrl && !neverDone && (mCnt == LAT - 1);
  assign div_done  = div_ctrl && !neverDone && (dCnt == LAT - 1);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quot, rem;
  assign prod = $signed(unit_op_a) * $signed(unit_op_b);
  assign {mult_hi, mult_lo} = prod;

  always_comb begin
    quot = '0;
    rem  = '0;
    if (unit_op_b != '0) begin
      quot = $signed(unit_op_a) / $signed(unit_op_b);
      rem  = $signed(unit_op_a) % $signed(unit_op_b);
    end
  end
  assign div_lo = quot;
  assign div_hi = rem;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one cycle at the negedge; the caller ends up in cycle 1 after the start.
  task automatic applyStimulus(input vec_t v, input bit expectDone);
    exp_t e;
    @(negedge clock);
    op_a       = v.a;
    op_b       = v.b;
    start_mult = (v.op != OP_DIV);
    start_div  = (v.op != OP_MULT);
    if (expectDone) begin
      e.hi  = v.expHi;
      e.lo  = v.expLo;
      e.dz  = v.expDz;
      e.lat = v.expDz ? 8'd1 : 8'd36;
      e.mc  = (v.op == OP_DIV) ? 8'd0 : 8'd34;
      e.dc  = (v.op == OP_DIV && !v.expDz) ? 8'd34 : 8'd0;
      expQ.push_back(e);
    end
    tick();
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  // Wait for done, counting cycles and unit-control activity, then compare with the queued expectation.
  task automatic checkOutput();
    int   cyc  = 1;
    int   mc   = 0;
    int   dc   = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (cyc <= 200) begin
      if (mult_ctrl) mc++;
      if (div_ctrl) dc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    checkVal("done_seen", 64'(seen), 64'd1);
    if (expQ.size() == 0) begin
      checkVal("scoreboard_nonempty", 64'd0, 64'd1);
      return;
    end
    e = expQ.pop_front();
    if (!seen) return;
    checkVal("hilo", {hi_out, lo_out}, {e.hi, e.lo});
    checkVal("latency", 64'(cyc), 64'(e.lat));
    checkVal("div_zero", 64'(div_zero), 64'(e.dz));
    checkVal("busy_at_done", 64'(busy), 64'd0);
    checkVal("mult_ctrl_cycles", 64'(mc), 64'(e.mc));
    checkVal("div_ctrl_cycles", 64'(dc), 64'(e.dc));
    archHiLo = {e.hi, e.lo};
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got expired expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t v;
    int   cyc;
    logic [134:0] allOut;

    vecs[0] = '{OP_MULT, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{OP_DIV,  32'd17,         32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1};
    vecs[2] = '{OP_BOTH, 32'd5,          32'd6,        32'h00000000, 32'd30,       1'b0};
    vecs[3] = '{OP_DIV,  32'd100,        32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4] = '{OP_DIV,  32'hFFFFFFEF,   32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[5] = '{OP_MULT, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[6] = '{OP_MULT, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7] = '{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};

    #1 reset = 1'b0;
    #2;
    allOut = {mult_ctrl, div_ctrl, unit_op_a, unit_op_b, unit_rst, hi_out, lo_out,
              busy, done, div_zero, timeout};
    checkVal("reset_outputs_zero", 64'(allOut === '0), 64'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Back-to-back table: each start lands in the previous operation's done cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], 1'b1);
      checkOutput();
    end

    // Flush during a divide at cycle 10; a new start two cycles later must be accepted.
    v = '{OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0};
    applyStimulus(v, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkVal("flush_unit_rst", 64'(unit_rst), 64'd1);
    checkVal("flush_no_done", 64'(done), 64'd0);
    checkVal("flush_busy", 64'(busy), 64'd1);
    checkVal("flush_no_timeout", 64'(timeout), 64'd0);
    checkVal("flush_div_ctrl_low", 64'(div_ctrl), 64'd0);
    tick();
    checkVal("flush_rst_one_cycle", 64'(unit_rst), 64'd0);
    checkVal("flush_idle_busy", 64'(busy), 64'd0);
    checkVal("flush_hilo_kept", {hi_out, lo_out}, archHiLo);
    v = '{OP_MULT, 32'd9, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFDC, 1'b0};
    applyStimulus(v, 1'b1);
    checkOutput();

    // Flush arriving in the commit cycle cancels the write.
    v = '{OP_MULT, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0};
    applyStimulus(v, 1'b0);
    repeat (34) tick();
    checkVal("commit_ctrl_dropped", 64'(mult_ctrl), 64'd0);
    checkVal("commit_busy_low", 64'(busy), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkVal("commit_flush_unit_rst", 64'(unit_rst), 64'd1);
    checkVal("commit_flush_no_done", 64'(done), 64'd0);
    tick();
    checkVal("commit_flush_hilo_kept", {hi_out, lo_out}, archHiLo);
    checkVal("commit_flush_no_done_after", 64'(done), 64'd0);

    // Watchdog: the unit never finishes.
    neverDone = 1'b1;
    v = '{OP_MULT, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0};
    applyStimulus(v, 1'b0);
    cyc = 1;
    while (!timeout && cyc < 100) begin
      tick();
      cyc++;
    end
    checkVal("timeout_cycle", 64'(cyc), 64'd49);
    checkVal("timeout_unit_rst", 64'(unit_rst), 64'd1);
    checkVal("timeout_busy", 64'(busy), 64'd1);
    tick();
    checkVal("timeout_busy_drop", 64'(busy), 64'd0);
    checkVal("timeout_one_cycle", 64'(timeout), 64'd0);
    checkVal("timeout_hilo_kept", {hi_out, lo_out}, archHiLo);
    neverDone = 1'b0;

    // Asynchronous reset in the middle of a multiply, then a fresh operation.
    v = '{OP_MULT, 32'd4, 32'd5, 32'd0, 32'd0, 1'b0};
    applyStimulus(v, 1'b0);
    repeat (10) tick();
    checkVal("pre_reset_mult_ctrl", 64'(mult_ctrl), 64'd1);
    #1 reset = 1'b0;
    #1;
    allOut = {mult_ctrl, div_ctrl, unit_op_a, unit_op_b, unit_rst, hi_out, lo_out,
              busy, done, div_zero, timeout};
    checkVal("midrun_reset_zero", 64'(allOut === '0), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    archHiLo = '0;
    v = '{OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0};
    applyStimulus(v, 1'b1);
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
